// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg: owner encoding and default widths shared by the arbiter
package sram_bus_arbiter_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int WSTRB_W = 4;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;
endpackage

// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: cpu-side fetch and data sram-like handshake bundle
interface sram_bus_arbiter_if
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic inst_addr_ok;
  logic inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic data_req;
  logic data_wr;
  logic [WSTRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic data_addr_ok;
  logic data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/sram_bus_arbiter_arb_wait_ctr.sv
// arb_wait_ctr: counts consecutive denied fetch cycles and flags starvation
module arb_wait_ctr #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic inst_gnt,
  output logic starve
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wire sat = cnt_q == CNT_W'(MAX_WAIT);
  // next count: clear on grant or idle, else saturating increment
  always_comb begin
    cnt_d = (!inst_req || inst_gnt) ? '0 : sat ? cnt_q : cnt_q + CNT_W'(1);
    starve = inst_req && sat;
  end
  // counter register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one 1-cycle sram between fetch and data ports, data first with anti-starvation
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic resetn,
  sram_bus_arbiter_if.slave bus,
  output logic sram_en,
  output logic [WSTRB_W-1:0] sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  logic ready_q, ready_d, resp_valid_q, resp_valid_d;
  owner_e resp_owner_q, resp_owner_d;
  logic starve, gnt_inst, gnt_data;
  arb_wait_ctr #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_wait (
    .clk(clk), .resetn(resetn), .inst_req(bus.inst_req), .inst_gnt(gnt_inst), .starve(starve)
  );
  // grant, sram drive and response routing
  always_comb begin
    ready_d = 1'b1;
    gnt_inst = ready_q && (starve || (bus.inst_req && !bus.data_req));
    gnt_data = ready_q && !starve && bus.data_req;
    resp_valid_d = gnt_inst || gnt_data;
    resp_owner_d = gnt_data ? OWN_DATA : OWN_INST;
    sram_en = gnt_inst || gnt_data;
    sram_we = (gnt_data && bus.data_wr) ? bus.data_wstrb : '0;
    sram_addr = gnt_data ? bus.data_addr : gnt_inst ? bus.inst_addr : '0;
    sram_wdata = bus.data_wdata;
    bus.inst_addr_ok = gnt_inst;
    bus.data_addr_ok = gnt_data;
    bus.inst_data_ok = resp_valid_q && resp_owner_q == OWN_INST;
    bus.data_data_ok = resp_valid_q && resp_owner_q == OWN_DATA;
    bus.inst_rdata = sram_rdata;
    bus.data_rdata = sram_rdata;
  end
  // ready and response-stage registers; reset drops any pending response
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWN_INST;
    end else begin
      ready_q <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed checks of grant, response latency, starvation and reset
module tb_sram_bus_arbiter;
  logic clk = 0, resetn = 0;
  logic sram_en;
  logic [3:0] sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  int n_tests = 0, n_fail = 0;
  sram_bus_arbiter_if bus();
  sram_bus_arbiter dut (
    .clk(clk), .resetn(resetn), .bus(bus), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic ei, ed, pi, pd;
    bus.inst_req = 1; bus.inst_addr = 32'h1c000000;
    bus.data_req = 1; bus.data_wr = 0; bus.data_wstrb = 4'hf;
    bus.data_addr = 32'h200; bus.data_wdata = 0; sram_rdata = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_iaok", bus.inst_addr_ok, 0);
    chk("rst_daok", bus.data_addr_ok, 0);
    chk("rst_en", sram_en, 0);
    chk("rst_we", sram_we, 0);
    cyc; resetn = 1; #1;
    chk("c1_daok", bus.data_addr_ok, 0);
    chk("c1_en", sram_en, 0);
    cyc; #1;
    chk("c2_daok", bus.data_addr_ok, 1);
    chk("c2_iaok", bus.inst_addr_ok, 0);
    chk("c2_addr", sram_addr, 32'h200);
    cyc; bus.inst_req = 0; bus.data_req = 0; #1;
    chk("c3_ddok", bus.data_data_ok, 1);
    chk("c3_idok", bus.inst_data_ok, 0);
    chk("c3_en", sram_en, 0);
    cyc; #1;
    chk("idle_ddok", bus.data_data_ok, 0);
    chk("idle_addr", sram_addr, 0);
    cyc; bus.inst_req = 1; #1;
    chk("ird_iaok", bus.inst_addr_ok, 1);
    chk("ird_addr", sram_addr, 32'h1c000000);
    chk("ird_we", sram_we, 0);
    cyc; bus.inst_req = 0; sram_rdata = 32'h02800c0c; #1;
    chk("ird_idok", bus.inst_data_ok, 1);
    chk("ird_rdata", bus.inst_rdata, 32'h02800c0c);
    chk("ird_ddok", bus.data_data_ok, 0);
    cyc; #1;
    chk("ird_idok_off", bus.inst_data_ok, 0);
    cyc; bus.data_req = 1; bus.data_wr = 1; bus.data_wstrb = 4'b0011;
    bus.data_addr = 32'h100; bus.data_wdata = 32'hdeadbeef; #1;
    chk("wr_daok", bus.data_addr_ok, 1);
    chk("wr_we", sram_we, 4'b0011);
    chk("wr_addr", sram_addr, 32'h100);
    chk("wr_wdata", sram_wdata, 32'hdeadbeef);
    cyc; bus.data_req = 0; bus.data_wr = 0; #1;
    chk("wr_ddok", bus.data_data_ok, 1);
    chk("wr_we_off", sram_we, 0);
    pi = 0; pd = 0;
    for (int i = 0; i < 10; i++) begin
      cyc; bus.inst_req = 1; bus.data_req = 1; bus.data_addr = 32'h300;
      bus.inst_addr = 32'h1c000010; #1;
      ei = (i % 5) == 4; ed = !ei;
      chk($sformatf("stv_iaok%0d", i), bus.inst_addr_ok, ei);
      chk($sformatf("stv_daok%0d", i), bus.data_addr_ok, ed);
      chk($sformatf("stv_idok%0d", i), bus.inst_data_ok, pi);
      chk($sformatf("stv_ddok%0d", i), bus.data_data_ok, pd);
      pi = ei; pd = ed;
    end
    cyc; bus.inst_req = 0; bus.data_req = 0; #1;
    chk("stv_idok_end", bus.inst_data_ok, 1);
    chk("stv_ddok_end", bus.data_data_ok, 0);
    cyc; bus.data_req = 1; bus.data_addr = 32'h400; #1;
    chk("b2b_daok", bus.data_addr_ok, 1);
    cyc; bus.data_req = 0; bus.inst_req = 1; bus.inst_addr = 32'h1c000020;
    sram_rdata = 32'h11111111; #1;
    chk("b2b_ddok", bus.data_data_ok, 1);
    chk("b2b_drdata", bus.data_rdata, 32'h11111111);
    chk("b2b_iaok", bus.inst_addr_ok, 1);
    chk("b2b_iaddr", sram_addr, 32'h1c000020);
    cyc; bus.inst_req = 0; sram_rdata = 32'h22222222; #1;
    chk("b2b_idok", bus.inst_data_ok, 1);
    chk("b2b_irdata", bus.inst_rdata, 32'h22222222);
    chk("b2b_ddok_off", bus.data_data_ok, 0);
    cyc; bus.data_req = 1; bus.data_addr = 32'h500; #1;
    chk("mrst_daok", bus.data_addr_ok, 1);
    #1 resetn = 0; bus.data_req = 0; #1;
    chk("mrst_daok_off", bus.data_addr_ok, 0);
    cyc; #1;
    chk("mrst_ddok", bus.data_data_ok, 0);
    cyc; resetn = 1; bus.inst_req = 1; bus.inst_addr = 32'h1c000040; #1;
    chk("mrst_ddok2", bus.data_data_ok, 0);
    chk("mrst_iaok_nr", bus.inst_addr_ok, 0);
    cyc; #1;
    chk("mrst_iaok", bus.inst_addr_ok, 1);
    cyc; bus.inst_req = 0; #1;
    chk("mrst_idok", bus.inst_data_ok, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Shares one single-port, 1-cycle-latency SRAM between the core's instruction-fetch port and its data port. Both masters use the req/addr_ok/data_ok sram-like handshake. The block sits between the CPU top and a unified memory, so fetch and load/store stop needing separate memories. Data accesses have priority. A wait counter stops instruction fetch from starving, and a response stage routes data_ok back to the owning master.

Parameters:
ADDR_W, 32, address width (byte address, passed through unchanged)
DATA_W, 32, data width
MAX_WAIT, 4, number of consecutive denied cycles after which a pending inst request wins arbitration
CNT_W, 3, wait-counter width; must hold MAX_WAIT

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request (read only)
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
inst_rdata  out  DATA_W  fetch read data
data_req  in  1  data request
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  4  byte enables for writes
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data read data valid / write complete this cycle
data_rdata  out  DATA_W  data read data
sram_en  out  1  SRAM access enable
sram_we  out  4  SRAM byte write enables
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid one cycle after the enabled read

Behaviour:
- Registers: ready (0 in reset, 1 on the first clk edge after resetn rises), resp_valid, resp_owner, wait_cnt. All are async-cleared to 0 while resetn=0.
- While resetn=0 or ready=0: all addr_ok, data_ok, sram_en and sram_we are 0.
- Grant (combinational, cycle T, only when ready=1):
  - starve = inst_req && wait_cnt==MAX_WAIT.
  - If starve: grant inst.
  - Else if data_req: grant data.
  - Else if inst_req: grant inst.
  - Else: no grant.
- Exactly one grant per cycle at most. The granted master's addr_ok=1 in T; the other's is 0.
- SRAM drive in T:
  - sram_en = any grant.
  - sram_addr = granted address, else 0.
  - sram_we = data_wstrb if data is granted with data_wr=1, else 0.
  - sram_wdata = data_wdata.
- Response: at the edge ending T, resp_valid <= any grant and resp_owner <= granted owner. In T+1, owner_data_ok = resp_valid && owner match. Latency is fixed at 1 cycle from addr_ok to data_ok, for reads and writes.
- Back-to-back: a new grant in T+1 is allowed while the T response is delivered. Full throughput is one access per cycle and no response buffering is needed.
- inst_rdata and data_rdata are both wired to sram_rdata and are qualified only by their data_ok.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle inst_req=1 and inst is not granted.
  - Cleared when inst is granted or inst_req=0.
- Simultaneous requests with the counter below MAX_WAIT: data wins. Counter at MAX_WAIT: inst wins, the data request stays pending, and data_addr_ok=0.
- Masters hold req/addr/wdata stable until addr_ok. The arbiter does not latch request fields.
- Reset asserted mid-operation: any pending resp_valid is dropped, with no data_ok after reset. The first grant is possible two edges after resetn rises: one edge sets ready, and grants start in the following cycle.
- MAX_WAIT=0: inst always wins whenever it requests, giving fetch-priority mode.

Decomposition:
- Shared package: owner encoding OWN_INST=1'b0, OWN_DATA=1'b1; DATA_W/ADDR_W defaults; WSTRB_W=4.
- One sub-module, arb_wait_ctr: the saturating wait counter plus the starve output, parameterised by MAX_WAIT/CNT_W.
- The grant logic and response stage stay in the top.

Test Plan:
- Reset release: hold resetn=0 with both reqs=1 → no addr_ok/sram_en. Release → first addr_ok in the second cycle after release, granted to data.
- Single inst read: inst_req=1, addr=0x1c000000, sram_rdata=0x02800c0c next cycle → inst_addr_ok in T, inst_data_ok with rdata 0x02800c0c in T+1, data_data_ok=0 throughout.
- Data write: data_req=1, wr=1, wstrb=4'b0011, addr=0x100, wdata=0xdeadbeef → sram_we=0011, sram_addr=0x100 in T, data_data_ok in T+1.
- Starvation (MAX_WAIT=4): both reqs held high continuously → data granted 4 cycles, inst granted on the 5th. Pattern repeats 4 data : 1 inst, and each data_ok follows its grant by exactly 1 cycle.
- Back-to-back mixed: data read in T, inst read in T+1 → data_data_ok in T+1, inst_data_ok in T+2, each with the corresponding sram_rdata.
- Mid-op reset: grant data read in T, pull resetn low before T+1 edge → no data_ok. After release, normal service resumes.
